// File: rtl/jk_ctrl_pkg.sv
// Shared types for the JK bank controller: opcodes and sequencer states.
package jk_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'b000,
    OP_SET    = 3'b001,
    OP_CLR    = 3'b010,
    OP_TOG    = 3'b011,
    OP_CNT_UP = 3'b100,
    OP_CNT_DN = 3'b101
  } jk_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_COUNT = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  // Counting opcodes are 10x; 11x is reserved and treated as a single-cycle NOP.
  function automatic logic is_count_op(input logic [2:0] op);
    return op[2:1] == 2'b10;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop: 00 hold, 10 set, 01 clear, 11 toggle.
module jk_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b10:   q <= 1'b1;
        2'b01:   q <= 1'b0;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_ctrl.sv
// Command sequencer driving per-bit J/K for a bank of JK cells.
// state | meaning
// IDLE  | ready for a command
// APPLY | single-cycle SET/CLR/TOG/NOP, J/K driven for one edge
// COUNT | one masked count step per cycle, step_cnt counts down to 1
// FIN   | DONE pulse, not ready
module jk_bank_ctrl
  import jk_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [CNT_W-1:0] cmd_len,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  state_e           state;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] mask_r;
  logic [CNT_W-1:0] step_cnt;
  logic [WIDTH-1:0] cnt_tog;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;
  logic             carry;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_FIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      op_r     <= '0;
      mask_r   <= '0;
      step_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_r     <= cmd_op;
            mask_r   <= cmd_mask;
            step_cnt <= cmd_len;
            if (!is_count_op(cmd_op))  state <= ST_APPLY;
            else if (cmd_len == '0)    state <= ST_FIN;
            else                       state <= ST_COUNT;
          end
        end
        ST_APPLY: state <= ST_FIN;
        ST_COUNT: begin
          step_cnt <= step_cnt - CNT_W'(1);
          if (step_cnt == CNT_W'(1)) state <= ST_FIN;
        end
        ST_FIN:   state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Ripple carry through masked bits only; unmasked bits neither toggle nor break the chain.
  always_comb begin
    cnt_tog = '0;
    carry   = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_tog[i] = mask_r[i] & carry;
      if (mask_r[i]) carry = carry & ((op_r == OP_CNT_DN) ? ~q[i] : q[i]);
    end
  end

  always_comb begin
    j_vec = '0;
    k_vec = '0;
    if (state == ST_APPLY) begin
      case (op_r)
        OP_SET: j_vec = mask_r;
        OP_CLR: k_vec = mask_r;
        OP_TOG: begin
          j_vec = mask_r;
          k_vec = mask_r;
        end
        default: ;
      endcase
    end else if (state == ST_COUNT) begin
      j_vec = cnt_tog;
      k_vec = cnt_tog;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_cell u_cell (
      .clk  (clk),
      .rst_n(rst_n),
      .j    (j_vec[gi]),
      .k    (k_vec[gi]),
      .q    (q[gi])
    );
  end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Self-checking bench for jk_bank_ctrl: directed scenarios plus random commands vs a masked-arithmetic model.
module tb_jk_bank_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_mask;
  logic [7:0] cmd_len;
  logic [7:0] q;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q;

  always #5 clk = ~clk;

  jk_bank_ctrl #(.WIDTH(8), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_mask (cmd_mask),
    .cmd_len  (cmd_len),
    .q        (q),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Masked bits gathered into an integer, incremented/decremented modulo 2^n, scattered back.
  function automatic logic [7:0] model_next(input logic [2:0] op, input logic [7:0] mask,
                                            input logic [7:0] cur);
    int n = 0;
    int v = 0;
    int idx = 0;
    logic [7:0] res;
    case (op)
      3'b001: return cur | mask;
      3'b010: return cur & ~mask;
      3'b011: return cur ^ mask;
      3'b100, 3'b101: begin
        for (int i = 0; i < 8; i++)
          if (mask[i]) begin
            v = v | (int'(cur[i]) << n);
            n++;
          end
        if (n == 0) return cur;
        v = (op == 3'b100) ? v + 1 : v - 1 + (1 << n);
        v = v % (1 << n);
        res = cur;
        for (int i = 0; i < 8; i++)
          if (mask[i]) begin
            res[i] = ((v >> idx) & 1) != 0;
            idx++;
          end
        return res;
      end
      default: return cur;
    endcase
  endfunction

  task automatic do_cmd(input logic [2:0] op, input logic [7:0] mask, input logic [7:0] len,
                        input bit hold);
    int f;
    int waited = 0;
    @(negedge clk);
    while (!cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("ready_before", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_mask  = mask;
    cmd_len   = len;
    @(posedge clk);
    #1;
    if (hold) begin
      cmd_op   = 3'b001;
      cmd_mask = 8'hFF;
      cmd_len  = 8'd3;
    end else begin
      cmd_valid = 1'b0;
    end
    f = (op == 3'b100 || op == 3'b101) ? int'(len) : 1;
    for (int k = 0; k <= f; k++) begin
      @(negedge clk);
      if (k >= 1) exp_q = model_next(op, mask, exp_q);
      chk("q_step", 32'(q), 32'(exp_q));
      chk("done_step", 32'(done), 32'(k == f));
      chk("busy_step", 32'(busy), 32'd1);
      chk("ready_step", 32'(cmd_ready), 32'd0);
      if (k == f) cmd_valid = 1'b0;
    end
    @(negedge clk);
    chk("q_idle", 32'(q), 32'(exp_q));
    chk("done_idle", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("ready_idle", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'b000;
    cmd_mask  = 8'h00;
    cmd_len   = 8'h00;
    exp_q     = 8'h00;

    #3 rst_n = 1'b0;
    #1;
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    do_cmd(3'b001, 8'hF0, 8'd0, 1'b0);
    chk("set_f0", 32'(q), 32'hF0);
    do_cmd(3'b011, 8'hFF, 8'd0, 1'b0);
    chk("tog_ff", 32'(q), 32'h0F);

    do_cmd(3'b010, 8'hFF, 8'd0, 1'b0);
    do_cmd(3'b001, 8'hFE, 8'd0, 1'b0);
    chk("preset_fe", 32'(q), 32'hFE);
    do_cmd(3'b100, 8'hFF, 8'd3, 1'b0);
    chk("cnt_up_wrap", 32'(q), 32'h01);

    do_cmd(3'b010, 8'hFF, 8'd0, 1'b0);
    do_cmd(3'b100, 8'h05, 8'd4, 1'b0);
    chk("cnt_sparse", 32'(q), 32'h00);

    do_cmd(3'b001, 8'h3C, 8'd0, 1'b0);
    do_cmd(3'b101, 8'hFF, 8'd0, 1'b0);
    chk("cnt_len0", 32'(q), 32'h3C);
    do_cmd(3'b111, 8'hFF, 8'd0, 1'b0);
    chk("rsvd_nop", 32'(q), 32'h3C);
    do_cmd(3'b101, 8'h00, 8'd3, 1'b0);
    chk("mask0_hold", 32'(q), 32'h3C);

    do_cmd(3'b010, 8'h0C, 8'd0, 1'b1);
    chk("hold_single", 32'(q), 32'h30);
    do_cmd(3'b101, 8'h33, 8'd5, 1'b1);

    for (int n = 0; n < 40; n++)
      do_cmd(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom_range(0, 6)),
             bit'($urandom_range(0, 1)));

    // Reset abandons a count in flight after four steps.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 3'b100;
    cmd_mask  = 8'hFF;
    cmd_len   = 8'd10;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k >= 1) exp_q = model_next(3'b100, 8'hFF, exp_q);
      chk("abort_q", 32'(q), 32'(exp_q));
    end
    #2 rst_n = 1'b0;
    #1;
    exp_q = 8'h00;
    chk("abort_rst_q", 32'(q), 32'h00);
    chk("abort_rst_ready", 32'(cmd_ready), 32'd1);
    chk("abort_rst_busy", 32'(busy), 32'd0);
    chk("abort_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_q_zero", 32'(q), 32'h00);
    end

    do_cmd(3'b011, 8'hA5, 8'd0, 1'b0);
    chk("post_abort_tog", 32'(q), 32'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
